nes_cpu_bus_responder: RTL
==========================

Name: nes_cpu_bus_responder

Overview:
- Responder end of the NesCpu bus: decodes addressOut/rw/dataOut each CPU bus cycle and returns read data to the CPU dataIn.
- Owns the 2 KB work RAM (mirrored) and the two controller ports ($4016/$4017).
- Forwards PRG ROM and PPU register accesses, and holds an open-bus latch for unmapped reads.
- Sits between NesCpu and the cartridge/PPU blocks at top level.

Parameters:
- RAM_ADDR_BITS, 11, work RAM depth is 2**RAM_ADDR_BITS bytes.
- PRG_ADDR_BITS, 15, PRG window width (32 KB, NROM).
- OPEN_BUS_RESET, 8'h00, reset value of the open-bus latch.

Ports:
- clock  in  1  system clock, 21.47727 MHz; single clock domain.
- reset  in  1  asynchronous, active-low reset.
- cpu_ce  in  1  one-cycle strobe marking the CPU bus-sample edge; all side effects commit only when high.
- address  in  16  CPU address.
- data_from_cpu  in  8  CPU write data.
- rw  in  1  1 = read, 0 = write.
- data_to_cpu  out  8  read data; combinational from address and state.
- pad1_buttons  in  8  pad 1 buttons, active high; bit0 = A, then B, Select, Start, Up, Down, Left, Right.
- pad2_buttons  in  8  pad 2 buttons, same order.
- pad_strobe  out  1  last value written to bit 0 of $4016.
- pad_oe  out  2  active low; bit0 low while reading $4016, bit1 low while reading $4017.
- prg_addr  out  PRG_ADDR_BITS  address[PRG_ADDR_BITS-1:0].
- prg_data  in  8  PRG ROM read data; combinational.
- ppu_cs  out  1  high when address is in $2000-$3FFF and cpu_ce is high.
- ppu_reg  out  3  address[2:0].
- ppu_rdata  in  8  PPU register read data.

Behaviour:
- Decode regions:
  - $0000-$1FFF: RAM, index = address[10:0], mirrored 4x.
  - $2000-$3FFF: PPU, mirrored every 8 bytes.
  - $4016: pad 1.
  - $4017: pad 2.
  - $8000-$FFFF: PRG.
  - All other addresses: unmapped.
- Read data:
  - RAM: asynchronous read of the addressed byte.
  - PPU: ppu_rdata.
  - PRG: prg_data.
  - Pads: {open_bus[7:5], 4'b0000, shift[0]}.
  - Unmapped: open_bus.
- Writes (cpu_ce=1 and rw=0):
  - RAM: byte written at the clock edge.
  - $4016: pad_strobe <= data_from_cpu[0].
  - PRG and unmapped: ignored; no state change.
  - $4017: ignored.
- Open-bus latch: on every cpu_ce, open_bus <= the byte on the bus that cycle (data_to_cpu on reads, data_from_cpu on writes).
- Pad shifters (one per port, 8-bit):
  - While pad_strobe=1: shift register reloads from its pad buttons every clock. A read returns the live A bit and does not shift.
  - While pad_strobe=0: each read with cpu_ce=1 at that port shifts right, inserting 1 at bit 7.
  - Bits read 1-8 are A..Right. Read 9 and later return 1.
  - Strobe 1->0: the button value from the last strobe-high clock is held.
  - A read of $4016 shifts only pad 1; a read of $4017 shifts only pad 2.
- pad_oe is combinational: low for the matching address when rw=1, regardless of cpu_ce.
- Latency: all reads are zero-cycle combinational, valid in the same cycle the CPU samples. Writes take effect at the cpu_ce edge.
- When cpu_ce=0: no RAM, strobe, shift or open-bus updates. Outputs still track address.
- Reset (asynchronous, at any time including mid-shift):
  - pad_strobe = 0.
  - Both shift registers = 8'hFF.
  - open_bus = OPEN_BUS_RESET.
  - RAM contents are not reset; the bench must not rely on them.
- Write to $4016 with data bit0=1 while the strobe is already 1: no change.

Decomposition:
- Package nes_bus_pkg:
  - Region enum {REG_RAM, REG_PPU, REG_PAD1, REG_PAD2, REG_PRG, REG_UNMAPPED}.
  - Address constants: PAD1_ADDR=16'h4016, PAD2_ADDR=16'h4017, PPU_BASE=16'h2000, PRG_BASE=16'h8000.
  - Button bit-index constants.
- Sub-module nes_pad_shifter (clock, reset, strobe, shift_en, buttons, serial_out), instantiated twice.

Test Plan:
- RAM mirror: write 8'hA5 to $0123 -> read $0923, $1123, $1923 all return 8'hA5.
- Pad sequence: pad1_buttons=8'b1000_0101, write $4016=1 then 0 -> nine $4016 reads give bit0 = 1,0,1,0,0,0,0,1,1; pad 2 remains unshifted.
- Strobe held: strobe=1, toggle pad1 A between reads -> each read returns the live A and never shifts.
- Open bus: read PRG $8000 with prg_data=8'h4C, then read $5000 -> 8'h4C; a following $4017 read has bits [7:5]=3'b010.
- Reset mid-shift: after 3 shifts assert reset -> pad_strobe=0, a $4016 read returns 1, open_bus=8'h00.
- cpu_ce gating: rw=0 at $0010 with cpu_ce=0 -> RAM unchanged; ppu_cs stays low for $2002 without cpu_ce.

Source files
------------

// File: rtl/nes_bus_pkg.sv
// Shared decode types and constants for the NES CPU bus responder.
// Region decode lives here so the top and any future bus masters agree on the map.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM,
    REG_PPU,
    REG_PAD1,
    REG_PAD2,
    REG_PRG,
    REG_UNMAPPED
  } region_e;

  localparam logic [15:0] PAD1_ADDR = 16'h4016;
  localparam logic [15:0] PAD2_ADDR = 16'h4017;
  localparam logic [15:0] PPU_BASE  = 16'h2000;
  localparam logic [15:0] PRG_BASE  = 16'h8000;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  // RAM is the bottom 8 KB, PPU the next 8 KB, PRG the upper 32 KB.
  function automatic region_e decode_region(input logic [15:0] a);
    region_e r;
    if (a[15:13] == 3'b000)                   r = REG_RAM;
    else if (a[15:13] == PPU_BASE[15:13])     r = REG_PPU;
    else if (a == PAD1_ADDR)                  r = REG_PAD1;
    else if (a == PAD2_ADDR)                  r = REG_PAD2;
    else if (a[15] == PRG_BASE[15])           r = REG_PRG;
    else                                      r = REG_UNMAPPED;
    return r;
  endfunction

endpackage

// File: rtl/nes_pad_shifter.sv
// Controller port shift register (4021-style): parallel load while strobed,
// serial shift with 1-fill otherwise.
module nes_pad_shifter
  import nes_bus_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       strobe,
  input  logic       shift_en,
  input  logic [7:0] buttons,
  output logic       serial_out
);

  logic [7:0] shift_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      shift_q <= '1;
    end else if (strobe) begin
      shift_q <= buttons;
    end else if (shift_en) begin
      shift_q <= {1'b1, shift_q[7:1]};
    end
  end

  // In parallel-load mode the A button is passed through live.
  assign serial_out = strobe ? buttons[BTN_A] : shift_q[0];

endmodule

// File: rtl/nes_cpu_bus_responder.sv
// CPU bus responder: work RAM, controller ports, PPU/PRG forwarding and the
// open-bus latch, all read combinationally in the CPU sample cycle.
module nes_cpu_bus_responder
  import nes_bus_pkg::*;
#(
  parameter int unsigned RAM_ADDR_BITS  = 11,
  parameter int unsigned PRG_ADDR_BITS  = 15,
  parameter logic [7:0]  OPEN_BUS_RESET = 8'h00
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     cpu_ce,
  input  logic [15:0]              address,
  input  logic [7:0]               data_from_cpu,
  input  logic                     rw,
  output logic [7:0]               data_to_cpu,
  input  logic [7:0]               pad1_buttons,
  input  logic [7:0]               pad2_buttons,
  output logic                     pad_strobe,
  output logic [1:0]               pad_oe,
  output logic [PRG_ADDR_BITS-1:0] prg_addr,
  input  logic [7:0]               prg_data,
  output logic                     ppu_cs,
  output logic [2:0]               ppu_reg,
  input  logic [7:0]               ppu_rdata
);

  logic [7:0] ram [2**RAM_ADDR_BITS];
  logic [7:0] open_bus;
  logic       pad1_bit;
  logic       pad2_bit;
  region_e    region;
  logic       bus_rd;
  logic       bus_wr;

  assign region   = decode_region(address);
  assign bus_rd   = cpu_ce && rw;
  assign bus_wr   = cpu_ce && !rw;
  assign prg_addr = address[PRG_ADDR_BITS-1:0];
  assign ppu_reg  = address[2:0];
  assign ppu_cs   = cpu_ce && (region == REG_PPU);
  assign pad_oe   = {~(rw && (region == REG_PAD2)), ~(rw && (region == REG_PAD1))};

  always_comb begin
    data_to_cpu = open_bus;
    unique case (region)
      REG_RAM:      data_to_cpu = ram[address[RAM_ADDR_BITS-1:0]];
      REG_PPU:      data_to_cpu = ppu_rdata;
      REG_PAD1:     data_to_cpu = {open_bus[7:5], 4'b0000, pad1_bit};
      REG_PAD2:     data_to_cpu = {open_bus[7:5], 4'b0000, pad2_bit};
      REG_PRG:      data_to_cpu = prg_data;
      REG_UNMAPPED: data_to_cpu = open_bus;
      default:      data_to_cpu = open_bus;
    endcase
  end

  // Work RAM has no reset; contents are undefined after power-up.
  always_ff @(posedge clock) begin
    if (bus_wr && region == REG_RAM) begin
      ram[address[RAM_ADDR_BITS-1:0]] <= data_from_cpu;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pad_strobe <= 1'b0;
      open_bus   <= OPEN_BUS_RESET;
    end else if (cpu_ce) begin
      open_bus <= rw ? data_to_cpu : data_from_cpu;
      if (!rw && region == REG_PAD1) begin
        pad_strobe <= data_from_cpu[0];
      end
    end
  end

  nes_pad_shifter u_pad1 (
    .clock      (clock),
    .reset      (reset),
    .strobe     (pad_strobe),
    .shift_en   (bus_rd && (region == REG_PAD1)),
    .buttons    (pad1_buttons),
    .serial_out (pad1_bit)
  );

  nes_pad_shifter u_pad2 (
    .clock      (clock),
    .reset      (reset),
    .strobe     (pad_strobe),
    .shift_en   (bus_rd && (region == REG_PAD2)),
    .buttons    (pad2_buttons),
    .serial_out (pad2_bit)
  );

endmodule
